cop_issue: RTL and testbench

- Host-side initiator for the co-processor interface, placed between the core's execute stage and an ISE co-processor.
- Accepts a custom-opcode instruction plus its operands from the core.
- Drives the co-processor request, waits for the co-processor to claim and answer, buffers the result, and hands it to the register-file write port.
- Unclaimed or over-long requests raise an illegal-instruction pulse.

---
 rtl/cop_issue_if.sv | 43 ++++
 rtl/cop_issue.sv | 129 ++++++++++++
 tb/tb_cop_issue.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cop_issue_if.sv
// Core-to-coprocessor issue bundle: issue, coprocessor request,
// register-file writeback and exception signals.
interface cop_issue_if;
    logic        iss_valid;
    logic        iss_ready;
    logic [31:0] iss_insn;
    logic [31:0] iss_rs1;
    logic [31:0] iss_rs2;
    logic        cop_valid;
    logic        cop_rdywr;
    logic [31:0] cop_insn;
    logic [31:0] cop_rs1;
    logic [31:0] cop_rs2;
    logic        cop_ready;
    logic        cop_wait;
    logic        cop_wr;
    logic [31:0] cop_rd;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        exc_illegal;
    logic [31:0] exc_insn;
    logic        busy;

    modport master (
        input  iss_valid, iss_insn, iss_rs1, iss_rs2,
        input  cop_ready, cop_wait, cop_wr, cop_rd, wb_ready,
        output iss_ready, cop_valid, cop_rdywr,
        output cop_insn, cop_rs1, cop_rs2,
        output wb_valid, wb_rd_addr, wb_data,
        output exc_illegal, exc_insn, busy
    );

    modport slave (
        output iss_valid, iss_insn, iss_rs1, iss_rs2,
        output cop_ready, cop_wait, cop_wr, cop_rd, wb_ready,
        input  iss_ready, cop_valid, cop_rdywr,
        input  cop_insn, cop_rs1, cop_rs2,
        input  wb_valid, wb_rd_addr, wb_data,
        input  exc_illegal, exc_insn, busy
    );
endinterface

// File: rtl/cop_issue.sv
// Host-side co-processor initiator: issues custom opcodes, waits for
// claim/result, buffers it for writeback, flags unclaimed requests.
module cop_issue #(
    parameter int TIMEOUT      = 4,
    parameter int WAIT_MAX     = 255,
    parameter bit CHECK_OPCODE = 1'b1,
    parameter bit BYPASS       = 1'b0
) (
    input logic         cop_clk,
    input logic         cop_rst,
    cop_issue_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WB,
        S_EXC
    } state_t;

    localparam logic [15:0] LP_TMO  = 16'(TIMEOUT);
    localparam logic [15:0] LP_WMAX = 16'(WAIT_MAX);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_insn;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [31:0] r_wb_data;
    logic [4:0]  r_rd_addr;
    logic [15:0] r_tmo;
    logic [15:0] r_wait;
    logic [15:0] w_tmo_inc;
    logic [15:0] w_wait_inc;
    logic        w_iss_ready;
    logic        w_issue;
    logic        w_op_ok;
    logic        w_done;
    logic        w_in_req;

    assign w_in_req    = (r_state == S_REQ);
    assign w_iss_ready = (r_state == S_IDLE) ||
                         ((r_state == S_WB) && bus.wb_ready);
    assign w_issue     = bus.iss_valid && w_iss_ready;
    assign w_done      = w_in_req && bus.cop_wr && bus.cop_ready;
    assign w_op_ok     = !CHECK_OPCODE ||
                         (bus.iss_insn[6:0] inside
                          {7'b0001011, 7'b0101011,
                           7'b1011011, 7'b1111011});

    // Saturating increments so a stuck co-processor never wraps a counter.
    assign w_tmo_inc  = (r_tmo == 16'hFFFF) ? r_tmo : r_tmo + 16'd1;
    assign w_wait_inc = (r_wait == 16'hFFFF) ? r_wait : r_wait + 16'd1;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_issue)
                    w_state_nxt = w_op_ok ? S_REQ : S_EXC;
            end
            S_REQ: begin
                if (bus.cop_wr) begin
                    if (bus.cop_ready)
                        w_state_nxt = BYPASS ? S_IDLE : S_WB;
                end else if (bus.cop_wait) begin
                    if (w_wait_inc >= LP_WMAX)
                        w_state_nxt = S_EXC;
                end else if (w_tmo_inc >= LP_TMO) begin
                    w_state_nxt = S_EXC;
                end
            end
            S_WB: begin
                if (bus.wb_ready) begin
                    if (w_issue)
                        w_state_nxt = w_op_ok ? S_REQ : S_EXC;
                    else
                        w_state_nxt = S_IDLE;
                end
            end
            S_EXC:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge cop_clk) begin
        if (cop_rst) begin
            r_state   <= S_IDLE;
            r_insn    <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd_addr <= '0;
            r_wb_data <= '0;
            r_tmo     <= '0;
            r_wait    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_insn    <= bus.iss_insn;
                r_rs1     <= bus.iss_rs1;
                r_rs2     <= bus.iss_rs2;
                r_rd_addr <= bus.iss_insn[11:7];
                r_tmo     <= '0;
                r_wait    <= '0;
            end else if (w_in_req && !bus.cop_wr) begin
                if (bus.cop_wait) begin
                    r_tmo  <= '0;
                    r_wait <= w_wait_inc;
                end else begin
                    r_tmo <= w_tmo_inc;
                end
            end
            if (!BYPASS && w_done)
                r_wb_data <= bus.cop_rd;
        end
    end

    assign bus.iss_ready   = w_iss_ready;
    assign bus.cop_valid   = w_in_req;
    assign bus.cop_rdywr   = w_in_req && (BYPASS ? bus.wb_ready : 1'b1);
    assign bus.cop_insn    = r_insn;
    assign bus.cop_rs1     = r_rs1;
    assign bus.cop_rs2     = r_rs2;
    assign bus.wb_valid    = (r_state == S_WB) || (BYPASS && w_done);
    assign bus.wb_rd_addr  = r_rd_addr;
    assign bus.wb_data     = (BYPASS && w_done) ? bus.cop_rd : r_wb_data;
    assign bus.exc_illegal = (r_state == S_EXC);
    assign bus.exc_insn    = (r_state == S_EXC) ? r_insn : 32'd0;
    assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_cop_issue.sv
// Directed bench for cop_issue: buffered instance (ba) and a
// BYPASS=1 instance (bb) sharing clock and reset.
module tb_cop_issue;
    logic cop_clk;
    logic cop_rst;
    int   n_vec;
    int   n_err;

    cop_issue_if ba();
    cop_issue_if bb();

    cop_issue #(
        .TIMEOUT(4), .WAIT_MAX(255),
        .CHECK_OPCODE(1'b1), .BYPASS(1'b0)
    ) u_a (
        .cop_clk(cop_clk), .cop_rst(cop_rst), .bus(ba)
    );

    cop_issue #(
        .TIMEOUT(4), .WAIT_MAX(255),
        .CHECK_OPCODE(1'b1), .BYPASS(1'b1)
    ) u_b (
        .cop_clk(cop_clk), .cop_rst(cop_rst), .bus(bb)
    );

    initial cop_clk = 1'b0;
    always #5 cop_clk = ~cop_clk;

    task automatic step();
        @(posedge cop_clk);
        #1;
    endtask

    task automatic issue_a(input logic [31:0] insn,
                           input logic [31:0] rs1,
                           input logic [31:0] rs2);
        ba.iss_valid = 1'b1;
        ba.iss_insn  = insn;
        ba.iss_rs1   = rs1;
        ba.iss_rs2   = rs2;
        step();
        ba.iss_valid = 1'b0;
    endtask

    task automatic test_reset();
        cop_rst = 1'b1;
        step();
        step();
        cop_rst = 1'b0;
        @(negedge cop_clk);
        n_vec++;
        if ({ba.busy, ba.cop_valid, ba.wb_valid, ba.exc_illegal,
             ba.iss_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 00001",
                     {ba.busy, ba.cop_valid, ba.wb_valid,
                      ba.exc_illegal, ba.iss_ready});
        end
        n_vec++;
        if ({ba.cop_insn, ba.cop_rs1, ba.cop_rs2, ba.wb_data,
             ba.wb_rd_addr, ba.exc_insn} !== '0) begin
            n_err++;
            $display("FAIL reset_data: insn %h rs1 %h data %h want 0",
                     ba.cop_insn, ba.cop_rs1, ba.wb_data);
        end
        step();
    endtask

    task automatic test_single_op();
        ba.iss_valid = 1'b1;
        ba.iss_insn  = 32'h0000_028B;
        ba.iss_rs1   = 32'h8000_0001;
        ba.iss_rs2   = 32'h1234_5678;
        @(negedge cop_clk);
        n_vec++;
        if (ba.iss_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_iss_ready: got %b want 1",
                     ba.iss_ready);
        end
        step();
        ba.iss_valid = 1'b0;
        ba.cop_wr    = 1'b1;
        ba.cop_rd    = 32'hDEAD_BEEF;
        @(negedge cop_clk);
        n_vec++;
        if ({ba.cop_valid, ba.cop_insn, ba.cop_rs1, ba.cop_rs2} !==
            {1'b1, 32'h0000_028B, 32'h8000_0001, 32'h1234_5678}) begin
            n_err++;
            $display("FAIL single_req: valid %b insn %h rs1 %h",
                     ba.cop_valid, ba.cop_insn, ba.cop_rs1);
        end
        step();
        ba.cop_wr   = 1'b0;
        ba.wb_ready = 1'b1;
        @(negedge cop_clk);
        n_vec++;
        if ({ba.wb_valid, ba.wb_data, ba.wb_rd_addr, ba.busy} !==
            {1'b1, 32'hDEAD_BEEF, 5'd5, 1'b1}) begin
            n_err++;
            $display("FAIL single_wb: valid %b data %h rd %0d want 1 deadbeef 5",
                     ba.wb_valid, ba.wb_data, ba.wb_rd_addr);
        end
        step();
        ba.wb_ready = 1'b0;
        @(negedge cop_clk);
        n_vec++;
        if ({ba.busy, ba.wb_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL single_done: busy %b wb_valid %b want 0 0",
                     ba.busy, ba.wb_valid);
        end
        step();
    endtask

    task automatic test_multi_cycle();
        issue_a(32'h0000_0A2B, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
        for (int i = 0; i < 11; i++) begin
            ba.cop_wait = (i < 10);
            ba.cop_wr   = (i == 10);
            ba.cop_rd   = 32'hCAFE_F00D;
            @(negedge cop_clk);
            n_vec++;
            if ({ba.cop_valid, ba.exc_illegal, ba.wb_valid,
                 ba.cop_insn, ba.cop_rs1, ba.cop_rs2} !==
                {3'b100, 32'h0000_0A2B, 32'hA5A5_A5A5,
                 32'h5A5A_5A5A}) begin
                n_err++;
                $display("FAIL multi_req%0d: v %b exc %b insn %h rs1 %h",
                         i, ba.cop_valid, ba.exc_illegal,
                         ba.cop_insn, ba.cop_rs1);
            end
            step();
        end
        ba.cop_wait = 1'b0;
        ba.cop_wr   = 1'b0;
        ba.wb_ready = 1'b1;
        @(negedge cop_clk);
        n_vec++;
        if ({ba.wb_valid, ba.wb_data, ba.wb_rd_addr} !==
            {1'b1, 32'hCAFE_F00D, 5'd20}) begin
            n_err++;
            $display("FAIL multi_wb: valid %b data %h rd %0d want 1 cafef00d 20",
                     ba.wb_valid, ba.wb_data, ba.wb_rd_addr);
        end
        step();
        ba.wb_ready = 1'b0;
        @(negedge cop_clk);
        n_vec++;
        if ({ba.wb_valid, ba.busy} !== 2'b00) begin
            n_err++;
            $display("FAIL multi_once: wb_valid %b busy %b want 0 0",
                     ba.wb_valid, ba.busy);
        end
        step();
    endtask

    task automatic test_unclaimed();
        issue_a(32'h1234_507B, 32'h1, 32'h2);
        for (int i = 0; i < 4; i++) begin
            @(negedge cop_clk);
            n_vec++;
            if ({ba.cop_valid, ba.exc_illegal} !== 2'b10) begin
                n_err++;
                $display("FAIL unclaimed_req%0d: valid %b exc %b want 1 0",
                         i, ba.cop_valid, ba.exc_illegal);
            end
            step();
        end
        @(negedge cop_clk);
        n_vec++;
        if ({ba.exc_illegal, ba.cop_valid, ba.wb_valid,
             ba.exc_insn} !== {3'b100, 32'h1234_507B}) begin
            n_err++;
            $display("FAIL unclaimed_exc: exc %b valid %b wb %b insn %h",
                     ba.exc_illegal, ba.cop_valid, ba.wb_valid,
                     ba.exc_insn);
        end
        step();
        @(negedge cop_clk);
        n_vec++;
        if ({ba.exc_illegal, ba.busy, ba.wb_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL unclaimed_after: exc %b busy %b wb %b want 0",
                     ba.exc_illegal, ba.busy, ba.wb_valid);
        end
        step();
    endtask

    task automatic test_bad_opcode();
        issue_a(32'h0020_8033, 32'h3, 32'h4);
        @(negedge cop_clk);
        n_vec++;
        if ({ba.exc_illegal, ba.cop_valid, ba.exc_insn} !==
            {2'b10, 32'h0020_8033}) begin
            n_err++;
            $display("FAIL badop_exc: exc %b valid %b insn %h",
                     ba.exc_illegal, ba.cop_valid, ba.exc_insn);
        end
        step();
        @(negedge cop_clk);
        n_vec++;
        if ({ba.exc_illegal, ba.cop_valid, ba.busy} !== 3'b000) begin
            n_err++;
            $display("FAIL badop_after: exc %b valid %b busy %b want 0",
                     ba.exc_illegal, ba.cop_valid, ba.busy);
        end
        step();
    endtask

    task automatic test_backpressure();
        issue_a(32'h0000_015B, 32'h9, 32'hA);
        ba.cop_wr = 1'b1;
        ba.cop_rd = 32'h1122_3344;
        step();
        ba.cop_wr = 1'b0;
        ba.cop_rd = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge cop_clk);
            n_vec++;
            if ({ba.wb_valid, ba.iss_ready, ba.wb_data,
                 ba.wb_rd_addr} !== {2'b10, 32'h1122_3344, 5'd2}) begin
                n_err++;
                $display("FAIL bp_hold%0d: v %b rdy %b data %h rd %0d",
                         i, ba.wb_valid, ba.iss_ready, ba.wb_data,
                         ba.wb_rd_addr);
            end
            step();
        end
        ba.wb_ready = 1'b1;
        @(negedge cop_clk);
        n_vec++;
        if ({ba.wb_valid, ba.iss_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL bp_release: wb_valid %b iss_ready %b want 1 1",
                     ba.wb_valid, ba.iss_ready);
        end
        step();
        ba.wb_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        issue_a(32'h0000_028B, 32'h1, 32'h1);
        ba.cop_wr = 1'b1;
        ba.cop_rd = 32'h0000_0001;
        step();
        ba.cop_wr    = 1'b0;
        ba.wb_ready  = 1'b1;
        ba.iss_valid = 1'b1;
        ba.iss_insn  = 32'h0000_030B;
        ba.iss_rs1   = 32'h7;
        ba.iss_rs2   = 32'h8;
        @(negedge cop_clk);
        n_vec++;
        if ({ba.wb_valid, ba.iss_ready, ba.wb_data} !==
            {2'b11, 32'h1}) begin
            n_err++;
            $display("FAIL b2b_first: wb %b rdy %b data %h want 1 1 1",
                     ba.wb_valid, ba.iss_ready, ba.wb_data);
        end
        step();
        ba.iss_valid = 1'b0;
        ba.wb_ready  = 1'b0;
        ba.cop_wr    = 1'b1;
        ba.cop_rd    = 32'h0000_0002;
        @(negedge cop_clk);
        n_vec++;
        if ({ba.cop_valid, ba.wb_valid, ba.cop_insn, ba.cop_rs1} !==
            {2'b10, 32'h0000_030B, 32'h7}) begin
            n_err++;
            $display("FAIL b2b_reissue: valid %b wb %b insn %h rs1 %h",
                     ba.cop_valid, ba.wb_valid, ba.cop_insn, ba.cop_rs1);
        end
        step();
        ba.cop_wr   = 1'b0;
        ba.wb_ready = 1'b1;
        @(negedge cop_clk);
        n_vec++;
        if ({ba.wb_valid, ba.wb_data, ba.wb_rd_addr} !==
            {1'b1, 32'h2, 5'd6}) begin
            n_err++;
            $display("FAIL b2b_second: v %b data %h rd %0d want 1 2 6",
                     ba.wb_valid, ba.wb_data, ba.wb_rd_addr);
        end
        step();
        ba.wb_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        issue_a(32'h0000_028B, 32'hFFFF_0000, 32'h0000_FFFF);
        step();
        cop_rst = 1'b1;
        step();
        cop_rst = 1'b0;
        @(negedge cop_clk);
        n_vec++;
        if ({ba.cop_valid, ba.busy, ba.wb_valid, ba.exc_illegal,
             ba.cop_insn, ba.cop_rs1, ba.cop_rs2, ba.wb_rd_addr} !==
            '0) begin
            n_err++;
            $display("FAIL rst_req: valid %b busy %b insn %h rs1 %h",
                     ba.cop_valid, ba.busy, ba.cop_insn, ba.cop_rs1);
        end
        step();
        issue_a(32'h0000_028B, 32'h5, 32'h6);
        ba.cop_wr = 1'b1;
        ba.cop_rd = 32'h0000_0077;
        step();
        ba.cop_wr = 1'b0;
        cop_rst   = 1'b1;
        step();
        cop_rst = 1'b0;
        @(negedge cop_clk);
        n_vec++;
        if ({ba.wb_valid, ba.busy, ba.wb_data} !== '0) begin
            n_err++;
            $display("FAIL rst_wb: wb %b busy %b data %h want 0",
                     ba.wb_valid, ba.busy, ba.wb_data);
        end
        step();
    endtask

    task automatic test_bypass();
        bb.iss_valid = 1'b1;
        bb.iss_insn  = 32'h0000_028B;
        bb.iss_rs1   = 32'h11;
        bb.iss_rs2   = 32'h22;
        step();
        bb.iss_valid = 1'b0;
        bb.wb_ready  = 1'b0;
        bb.cop_ready = 1'b0;
        bb.cop_wr    = 1'b1;
        bb.cop_rd    = 32'hBEEF_0001;
        for (int i = 0; i < 6; i++) begin
            @(negedge cop_clk);
            n_vec++;
            if ({bb.cop_valid, bb.cop_rdywr, bb.wb_valid,
                 bb.exc_illegal, bb.cop_insn} !==
                {4'b1000, 32'h0000_028B}) begin
                n_err++;
                $display("FAIL byp_hold%0d: v %b rdywr %b wb %b exc %b",
                         i, bb.cop_valid, bb.cop_rdywr, bb.wb_valid,
                         bb.exc_illegal);
            end
            step();
        end
        bb.wb_ready  = 1'b1;
        bb.cop_ready = 1'b1;
        @(negedge cop_clk);
        n_vec++;
        if ({bb.cop_rdywr, bb.wb_valid, bb.wb_data, bb.wb_rd_addr} !==
            {2'b11, 32'hBEEF_0001, 5'd5}) begin
            n_err++;
            $display("FAIL byp_fwd: rdywr %b wb %b data %h rd %0d",
                     bb.cop_rdywr, bb.wb_valid, bb.wb_data,
                     bb.wb_rd_addr);
        end
        step();
        bb.cop_wr    = 1'b0;
        bb.wb_ready  = 1'b0;
        bb.cop_ready = 1'b0;
        @(negedge cop_clk);
        n_vec++;
        if ({bb.busy, bb.cop_valid, bb.wb_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL byp_idle: busy %b valid %b wb %b want 0",
                     bb.busy, bb.cop_valid, bb.wb_valid);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        cop_rst = 1'b1;
        ba.iss_valid = 1'b0;
        ba.iss_insn  = '0;
        ba.iss_rs1   = '0;
        ba.iss_rs2   = '0;
        ba.cop_ready = 1'b1;
        ba.cop_wait  = 1'b0;
        ba.cop_wr    = 1'b0;
        ba.cop_rd    = '0;
        ba.wb_ready  = 1'b0;
        bb.iss_valid = 1'b0;
        bb.iss_insn  = '0;
        bb.iss_rs1   = '0;
        bb.iss_rs2   = '0;
        bb.cop_ready = 1'b0;
        bb.cop_wait  = 1'b0;
        bb.cop_wr    = 1'b0;
        bb.cop_rd    = '0;
        bb.wb_ready  = 1'b0;
        test_reset();
        test_single_op();
        test_multi_cycle();
        test_unclaimed();
        test_bad_opcode();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
